// File: rtl/tmr_vote_monitor.sv
// TMR vote monitor: majority vote, replica health tracking, fault counting.
// Optional in-block fault injection enabled by defining TMR_VOTE_INJ_EN.
module tmr_vote_monitor #(
  parameter int W          = 8,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     cnt_a,
  input  logic [W-1:0]     cnt_b,
  input  logic [W-1:0]     cnt_c,
  input  logic [W-1:0]     stat_a,
  input  logic [W-1:0]     stat_b,
  input  logic [W-1:0]     stat_c,
`ifdef TMR_VOTE_INJ_EN
  input  logic [1:0]       inj_sel,
  input  logic [W-1:0]     inj_mask,
`endif
  input  logic             clr,
  output logic [W-1:0]     voted_counter,
  output logic [W-1:0]     voted_status,
  output logic             out_valid,
  output logic [2:0]       mismatch,
  output logic [2:0]       fail_mask,
  output logic [CNT_W-1:0] fault_count,
  output logic [1:0]       health,
  output logic             uncorrectable
);

  localparam int WW = 2 * W;
  localparam logic [1:0] H_OK   = 2'd0;
  localparam logic [1:0] H_DEG  = 2'd1;
  localparam logic [1:0] H_FAIL = 2'd2;

  function automatic logic [1:0] pop3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

  logic [W-1:0]       vc_q, vc_d, vs_q, vs_d;
  logic               ov_q, ov_d;
  logic [2:0]         mm_q, mm_d;
  logic [2:0]         fm_q, fm_d;
  logic [CNT_W-1:0]   fc_q, fc_d;
  logic [1:0]         hl_q, hl_d;
  logic               unc_q, unc_d;
  logic [2:0][3:0]    run_q, run_d;

  logic [W-1:0]       sa, sb, sc;
  logic [2:0][WW-1:0] w;
  logic [WW-1:0]      maj, vote_w;
  logic               eq_ab, eq_ac, eq_bc;
  logic               pair_eq, hold, unc;
  logic [2:0]         mm;

  always_comb begin
    sa = stat_a;
    sb = stat_b;
    sc = stat_c;
`ifdef TMR_VOTE_INJ_EN
    case (inj_sel)
      2'd0:    sa = stat_a ^ inj_mask;
      2'd1:    sb = stat_b ^ inj_mask;
      2'd2:    sc = stat_c ^ inj_mask;
      default: ;
    endcase
`endif
    w[0]  = {cnt_a, sa};
    w[1]  = {cnt_b, sb};
    w[2]  = {cnt_c, sc};
    maj   = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    eq_ab = (w[0] == w[1]);
    eq_ac = (w[0] == w[2]);
    eq_bc = (w[1] == w[2]);
  end

  always_comb begin
    vc_d    = vc_q;
    vs_d    = vs_q;
    ov_d    = 1'b0;
    mm_d    = 3'b000;
    fm_d    = fm_q;
    fc_d    = fc_q;
    hl_d    = hl_q;
    unc_d   = 1'b0;
    run_d   = run_q;
    vote_w  = maj;
    pair_eq = 1'b1;
    hold    = 1'b0;
    mm      = {w[2] != maj, w[1] != maj, w[0] != maj};
    unc     = !(eq_ab || eq_ac || eq_bc);
    if (clr) begin
      fm_d  = 3'b000;
      fc_d  = '0;
      run_d = '0;
      hl_d  = H_OK;
      if (in_valid) begin
        ov_d = 1'b1;
        {vc_d, vs_d} = maj;
      end
    end else if (in_valid) begin
      ov_d = 1'b1;
      // One replica masked: vote only between the two survivors
      if (pop3(fm_q) == 2'd1) begin
        unique case (1'b1)
          fm_q[0]: begin pair_eq = eq_bc; vote_w = w[1]; end
          fm_q[1]: begin pair_eq = eq_ac; vote_w = w[0]; end
          fm_q[2]: begin pair_eq = eq_ab; vote_w = w[0]; end
          default: ;
        endcase
        for (int i = 0; i < 3; i++)
          if (!fm_q[i]) mm[i] = !pair_eq;
        unc  = !pair_eq;
        hold = !pair_eq;
      end
      if (hl_q != H_FAIL && !hold)
        {vc_d, vs_d} = vote_w;
      mm_d  = mm;
      unc_d = unc;
      for (int i = 0; i < 3; i++) begin
        if (!fm_q[i]) begin
          if (mm[i]) begin
            run_d[i] = run_q[i] + 4'd1;
            if (run_d[i] == 4'(ERR_THRESH)) fm_d[i] = 1'b1;
          end else begin
            run_d[i] = 4'd0;
          end
        end
      end
      if ((|mm) && (fc_q != {CNT_W{1'b1}}))
        fc_d = fc_q + 1'b1;
      if (hl_q != H_FAIL) begin
        if (pop3(fm_d) >= 2'd2 || unc) hl_d = H_FAIL;
        else if (pop3(fm_d) == 2'd1)   hl_d = H_DEG;
        else                           hl_d = H_OK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vc_q  <= '0;
      vs_q  <= '0;
      ov_q  <= 1'b0;
      mm_q  <= 3'b000;
      fm_q  <= 3'b000;
      fc_q  <= '0;
      hl_q  <= H_OK;
      unc_q <= 1'b0;
      run_q <= '0;
    end else begin
      vc_q  <= vc_d;
      vs_q  <= vs_d;
      ov_q  <= ov_d;
      mm_q  <= mm_d;
      fm_q  <= fm_d;
      fc_q  <= fc_d;
      hl_q  <= hl_d;
      unc_q <= unc_d;
      run_q <= run_d;
    end
  end

  assign voted_counter = vc_q;
  assign voted_status  = vs_q;
  assign out_valid     = ov_q;
  assign mismatch      = mm_q;
  assign fail_mask     = fm_q;
  assign fault_count   = fc_q;
  assign health        = hl_q;
  assign uncorrectable = unc_q;

endmodule
